// File: rtl/pkt_prio_sched.sv
// Strict-priority egress scheduler: sorts a free-running input stream into per-class
// FIFOs and presents the lowest-numbered non-empty class on a registered valid/ready port.
module pkt_prio_sched #(
   parameter int DWIDTH      = 32,
   parameter int PRIOR_WIDTH = 6,
   parameter int NUM_CLASS   = 8,
   parameter int DEPTH       = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [DWIDTH-1:0]      in_data,
   input  logic [PRIOR_WIDTH-1:0] in_prior,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DWIDTH-1:0]      out_data,
   output logic [PRIOR_WIDTH-1:0] out_prior,
   output logic [NUM_CLASS-1:0]   class_nonempty,
   output logic [15:0]            drop_cnt
);

   localparam int CW = $clog2(NUM_CLASS);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   FULL_CNT  = (PW+1)'(DEPTH);
   localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [CW-1:0] TOP_CLASS = CW'(NUM_CLASS-1);

   logic [DWIDTH-1:0] mem_q [NUM_CLASS][DEPTH];

   logic [PW:0]   count_q  [NUM_CLASS];
   logic [PW:0]   count_d  [NUM_CLASS];
   logic [PW-1:0] wr_ptr_q [NUM_CLASS];
   logic [PW-1:0] wr_ptr_d [NUM_CLASS];
   logic [PW-1:0] rd_ptr_q [NUM_CLASS];
   logic [PW-1:0] rd_ptr_d [NUM_CLASS];

   logic [NUM_CLASS-1:0]   nonempty_q, nonempty_d;
   logic [15:0]            drop_cnt_q, drop_cnt_d;
   logic                   out_valid_q, out_valid_d;
   logic [DWIDTH-1:0]      out_data_q, out_data_d;
   logic [PRIOR_WIDTH-1:0] out_prior_q, out_prior_d;

   logic [CW-1:0] cls;
   logic [CW-1:0] sel;
   logic          any;
   logic          full;
   logic          enq;
   logic          drop;
   logic          load;

   // Tags beyond the top class are clamped into it; tag zero maps to the reserved class 0.
   assign cls  = (32'(in_prior) >= 32'(NUM_CLASS)) ? TOP_CLASS : in_prior[CW-1:0];
   assign full = (count_q[cls] == FULL_CNT);
   assign enq  = in_valid && (cls != '0) && !full;
   assign drop = in_valid && !enq;

   // Lowest-numbered non-empty class wins; class 0 never holds data.
   always_comb begin
      sel = '0;
      any = 1'b0;
      for (int k = NUM_CLASS-1; k >= 1; k--) begin
         if (count_q[k] != '0) begin
            sel = CW'(k);
            any = 1'b1;
         end
      end
   end

   assign load = any && (!out_valid_q || out_ready);

   always_comb begin
      for (int k = 0; k < NUM_CLASS; k++) begin
         count_d[k]    = count_q[k];
         wr_ptr_d[k]   = wr_ptr_q[k];
         rd_ptr_d[k]   = rd_ptr_q[k];
         nonempty_d[k] = 1'b0;
      end
      if (enq) begin
         wr_ptr_d[cls] = wr_ptr_q[cls] + PTR_ONE;
      end
      if (load) begin
         rd_ptr_d[sel] = rd_ptr_q[sel] + PTR_ONE;
      end
      // A class written and read in the same cycle keeps its count.
      for (int k = 0; k < NUM_CLASS; k++) begin
         if ((enq && (cls == CW'(k))) && !(load && (sel == CW'(k)))) begin
            count_d[k] = count_q[k] + CNT_ONE;
         end else if ((load && (sel == CW'(k))) && !(enq && (cls == CW'(k)))) begin
            count_d[k] = count_q[k] - CNT_ONE;
         end
         nonempty_d[k] = (k != 0) && (count_d[k] != '0);
      end
   end

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   // Data and class hold their last value once the register empties.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_prior_d = out_prior_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = mem_q[sel][rd_ptr_q[sel]];
         out_prior_d = PRIOR_WIDTH'(sel);
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         mem_q[cls][wr_ptr_q[cls]] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_CLASS; k++) begin
            count_q[k]  <= '0;
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
         end
         nonempty_q  <= '0;
         drop_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_prior_q <= '0;
      end else begin
         for (int k = 0; k < NUM_CLASS; k++) begin
            count_q[k]  <= count_d[k];
            wr_ptr_q[k] <= wr_ptr_d[k];
            rd_ptr_q[k] <= rd_ptr_d[k];
         end
         nonempty_q  <= nonempty_d;
         drop_cnt_q  <= drop_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_prior_q <= out_prior_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;
   assign out_prior      = out_prior_q;
   assign class_nonempty = nonempty_q;
   assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_pkt_prio_sched.sv
// Bench for pkt_prio_sched: queue-based reference model feeds a scoreboard that a
// separate monitor drains on every output handshake.
module tb_pkt_prio_sched;

   localparam int DW  = 32;
   localparam int PWD = 6;
   localparam int NC  = 8;
   localparam int DEP = 4;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic [DW-1:0]  in_data;
   logic [PWD-1:0] in_prior;
   logic           out_valid;
   logic           out_ready;
   logic [DW-1:0]  out_data;
   logic [PWD-1:0] out_prior;
   logic [NC-1:0]  class_nonempty;
   logic [15:0]    drop_cnt;

   typedef struct packed {
      logic [DW-1:0]  d;
      logic [PWD-1:0] p;
   } exp_t;

   exp_t sb[$];
   exp_t monE;

   logic [DW-1:0]  mq [NC][$];
   logic           mV;
   logic [DW-1:0]  mD;
   logic [PWD-1:0] mP;
   int             mDrop;

   int vectors;
   int miscompares;

   pkt_prio_sched #(
      .DWIDTH(DW), .PRIOR_WIDTH(PWD), .NUM_CLASS(NC), .DEPTH(DEP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_prior(in_prior),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_prior(out_prior),
      .class_nonempty(class_nonempty),
      .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compare(input string tag, input string name,
                          input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s/%s: got %0h, expected %0h at %0t", tag, name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < NC; k++) mq[k].delete();
      mV    = 1'b0;
      mD    = '0;
      mP    = '0;
      mDrop = 0;
      sb.delete();
   endtask

   // One clock edge of the scheduler as described by its rules, using the inputs just sampled.
   task automatic modelStep();
      int   sel;
      int   cls;
      bit   accept;
      exp_t e;
      sel = 0;
      for (int k = 1; k < NC; k++) begin
         if (mq[k].size() != 0) begin
            sel = k;
            break;
         end
      end
      cls    = (int'(in_prior) >= NC) ? NC-1 : int'(in_prior);
      accept = in_valid && (cls != 0) && (mq[cls].size() < DEP);
      if (in_valid && !accept && mDrop < 65535) mDrop++;
      if (sel != 0 && (!mV || out_ready)) begin
         mD  = mq[sel].pop_front();
         mP  = PWD'(sel);
         mV  = 1'b1;
         e.d = mD;
         e.p = mP;
         sb.push_back(e);
      end else if (mV && out_ready) begin
         mV = 1'b0;
      end
      if (accept) mq[cls].push_back(in_data);
   endtask

   task automatic checkOutput(input string tag);
      logic [NC-1:0] expNe;
      expNe = '0;
      for (int k = 1; k < NC; k++) expNe[k] = (mq[k].size() != 0);
      compare(tag, "out_valid", 64'(out_valid), 64'(mV));
      compare(tag, "class_nonempty", 64'(class_nonempty), 64'(expNe));
      compare(tag, "drop_cnt", 64'(drop_cnt), 64'(mDrop));
      if (mV) begin
         compare(tag, "out_data", 64'(out_data), 64'(mD));
         compare(tag, "out_prior", 64'(out_prior), 64'(mP));
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                                input logic [PWD-1:0] p, input logic r, input string tag);
      in_valid  = v;
      in_data   = d;
      in_prior  = p;
      out_ready = r;
      @(posedge clk);
      #1;
      modelStep();
      checkOutput(tag);
   endtask

   task automatic checkZeroOutputs(input string tag);
      compare(tag, "out_valid", 64'(out_valid), 64'd0);
      compare(tag, "out_data", 64'(out_data), 64'd0);
      compare(tag, "out_prior", 64'(out_prior), 64'd0);
      compare(tag, "class_nonempty", 64'(class_nonempty), 64'd0);
      compare(tag, "drop_cnt", 64'(drop_cnt), 64'd0);
   endtask

   task automatic doReset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_prior  = '0;
      out_ready = 1'b0;
      #1;
      modelReset();
      checkZeroOutputs("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: every handshake must deliver the oldest word the model loaded.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL mon/unexpected: got data %0h prior %0h, expected no word", out_data, out_prior);
         end else begin
            monE = sb.pop_front();
            compare("mon", "out_data", 64'(out_data), 64'(monE.d));
            compare("mon", "out_prior", 64'(out_prior), 64'(monE.p));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      in_prior    = '0;
      out_ready   = 1'b0;
      modelReset();
      #1;
      doReset();

      // Reset asserted between edges while words are queued and presented.
      applyStimulus(1'b1, 32'h31, 6'd3, 1'b0, "t1");
      applyStimulus(1'b1, 32'h32, 6'd3, 1'b0, "t1");
      compare("t1", "pre_valid", 64'(out_valid), 64'd1);
      compare("t1", "pre_ne", 64'(class_nonempty), 64'h08);
      #2;
      rst_n = 1'b0;
      #1;
      checkZeroOutputs("t1_async");
      modelReset();
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b0, "t1_idle");

      // Priority order with the first word latched alone.
      doReset();
      applyStimulus(1'b1, 32'hA, 6'd5, 1'b0, "t2");
      applyStimulus(1'b1, 32'hB, 6'd2, 1'b0, "t2");
      applyStimulus(1'b1, 32'hC, 6'd2, 1'b0, "t2");
      applyStimulus(1'b1, 32'hD, 6'd7, 1'b0, "t2");
      compare("t2", "latchA", 64'(out_data), 64'hA);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, '0, 1'b1, "t2_drain");

      // Class 1 overflow.
      doReset();
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, DW'(32'h100 + i), 6'd1, 1'b0, "t3");
      compare("t3", "drop_cnt", 64'(drop_cnt), 64'd1);
      compare("t3", "class_nonempty", 64'(class_nonempty), 64'h02);
      compare("t3", "head", 64'(out_data), 64'h100);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, '0, 1'b1, "t3_drain");

      // Invalid tag and clamp.
      doReset();
      applyStimulus(1'b1, 32'h11, 6'd0, 1'b1, "t4");
      applyStimulus(1'b1, 32'h22, 6'd63, 1'b1, "t4");
      applyStimulus(1'b0, '0, '0, 1'b1, "t4");
      compare("t4", "drop_cnt", 64'(drop_cnt), 64'd1);
      compare("t4", "clamp_data", 64'(out_data), 64'h22);
      compare("t4", "clamp_prior", 64'(out_prior), 64'd7);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1, "t4_drain");

      // Continuous streaming through class 4, wrapping the pointers several times.
      doReset();
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, DW'(i), 6'd4, 1'b1, "t5");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1, "t5_tail");
      compare("t5", "drop_cnt", 64'(drop_cnt), 64'd0);

      // Backpressure stall: ready 0,0,1 with words waiting.
      doReset();
      applyStimulus(1'b1, 32'h61, 6'd6, 1'b0, "t6");
      applyStimulus(1'b1, 32'h62, 6'd6, 1'b0, "t6");
      applyStimulus(1'b1, 32'h63, 6'd6, 1'b0, "t6");
      applyStimulus(1'b0, '0, '0, 1'b0, "t6_stall");
      applyStimulus(1'b0, '0, '0, 1'b0, "t6_stall");
      compare("t6", "held", 64'(out_data), 64'h61);
      applyStimulus(1'b0, '0, '0, 1'b1, "t6_hs");
      compare("t6", "next", 64'(out_data), 64'h62);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, '0, 1'b1, "t6_drain");

      // Randomised traffic: a congested phase then a mostly-flowing phase.
      doReset();
      for (int i = 0; i < 400; i++) begin
         logic           v;
         logic           r;
         logic [PWD-1:0] p;
         v = ($urandom_range(0, 3) != 0);
         p = ($urandom_range(0, 9) == 0) ? PWD'($urandom_range(8, 63)) : PWD'($urandom_range(0, 7));
         if (i < 200) r = ($urandom_range(0, 3) == 0);
         else         r = ($urandom_range(0, 3) != 0);
         applyStimulus(v, DW'($urandom), p, r, "rand");
      end
      for (int i = 0; i < 40; i++) applyStimulus(1'b0, '0, '0, 1'b1, "final_drain");
      compare("final", "sb_left", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pkt_prio_sched.md
# pkt_prio_sched

Strict-priority egress scheduler placed directly downstream of the packet prioritiser stage. It accepts the prioritiser's free-running `valid/data/prior` stream, which has no backpressure, and sorts each word into one of `NUM_CLASS` per-priority FIFOs. It presents the lowest-numbered non-empty class on a registered valid/ready output port. Words are dropped and counted when their class queue is full or their priority is zero.

## Interface
Parameters:
- `DWIDTH`, 32, data word width.
- `PRIOR_WIDTH`, 6, width of the priority tag.
- `NUM_CLASS`, 8, number of priority classes. Class 0 is reserved (invalid); classes 1..NUM_CLASS-1 hold data.
- `DEPTH`, 4, entries per class FIFO. Power of two, ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input word present this cycle. There is no ready signal, so the block must sample every cycle.
- `in_data` in DWIDTH: input word.
- `in_prior` in PRIOR_WIDTH: priority tag.
- `out_valid` out 1: output register holds a word.
- `out_ready` in 1: consumer takes the word when `out_valid && out_ready`.
- `out_data` out DWIDTH: output word.
- `out_prior` out PRIOR_WIDTH: class of the output word, zero-extended.
- `class_nonempty` out NUM_CLASS: bit k is high when class FIFO k holds ≥1 entry. Bit 0 is always 0.
- `drop_cnt` out 16: count of dropped words. Saturates at 16'hFFFF.

## Operation
- **Class mapping:** `cls = (in_prior >= NUM_CLASS) ? NUM_CLASS-1 : in_prior`.
- **Invalid tag:** `in_valid && in_prior==0` drops the word and increments `drop_cnt`.
- **Per-class FIFO:** each class has its own storage, read/write pointers of width log2(DEPTH) that wrap modulo DEPTH, and a count of width log2(DEPTH)+1.
- **Enqueue:** on `in_valid`, if `count[cls] < DEPTH`, write the word and advance the write pointer.
  - Otherwise drop the word and increment `drop_cnt`.
  - The fullness check uses the pre-edge count. A full class drops the word even if it is dequeued in the same cycle.
- **Arbiter (combinational):** `sel` is the lowest k in 1..NUM_CLASS-1 with `count[k]!=0`. `any` is the OR of those bits.
- **Output register load:** `load = any && (!out_valid || out_ready)`.
  - On `load`, the head of `sel` moves into `out_data`/`out_prior`, `out_valid` goes to 1, and the read pointer of `sel` advances.
- **Output register drain:** if `out_valid && out_ready && !any`, `out_valid` goes to 0.
  - `out_data` and `out_prior` hold their last value when `out_valid` is 0.
- **Simultaneous enqueue and dequeue on one class:** the count stays unchanged and both pointers advance.
- **Ordering:** strict priority with no aging. Lower classes can starve higher ones indefinitely. Order is FIFO within a class.
- **Reset (rst_n low, asynchronous):**
  - all counts and pointers go to 0;
  - `out_valid`=0, `out_data`=0, `out_prior`=0;
  - `class_nonempty`=0, `drop_cnt`=0.
  - Reset asserted mid-operation discards all queued and presented words. No partial state survives.
  - Storage arrays need no reset.

## Timing
- **Latency:** a word sampled at edge N into an empty block with `out_valid`=0 appears on `out_valid` after edge N+1. The enqueue edge to output-valid latency is 1 cycle.
- **Throughput:** one output per cycle while `out_ready`=1 and some class is non-empty.
- **Registered outputs:** `class_nonempty` and `drop_cnt` are register outputs and reflect the state after each edge.
- **`out_valid` handshake:** `out_valid` never deasserts without a handshake. `out_data`/`out_prior` are stable while `out_valid && !out_ready`.
- **Arbitration point:** the arbiter re-evaluates every cycle. A higher-priority word arriving while a lower one is already in the output register waits behind it and is not preempted.
- **Drop counter:** the input path drops at most one word per cycle, so `drop_cnt` increments by at most 1 per cycle.

## Test plan
1. **Reset mid-traffic:**
   - Stimulus: fill class 3 with 2 words, assert `out_valid`, then pulse `rst_n` low between edges.
   - Required: all outputs 0 immediately; after release, `class_nonempty`=0 and `out_valid` stays 0 with no input.
2. **Priority order:**
   - Stimulus: with `out_ready`=0, enqueue D=0xA (prior 5), 0xB (prior 2), 0xC (prior 2), 0xD (prior 7).
   - Required: `out_data`=0xA latched first (it arrived alone).
   - Then raise `out_ready`. Required sequence: 0xB/2, 0xC/2, 0xD/7, then `out_valid`=0.
3. **Full and drop:**
   - Stimulus: DEPTH=4, `out_ready`=0, 6 words at prior 1.
   - Required: first word in the output register, next 4 queued, 6th dropped, `drop_cnt`=1, `class_nonempty`[1]=1.
4. **Invalid and clamp:**
   - Stimulus: prior 0 with data 0x11, then prior 63 with data 0x22.
   - Required: `drop_cnt`=1; 0x22 emerges with `out_prior`=7.
5. **Wrap-around streaming:**
   - Stimulus: continuous prior-4 input with `out_ready`=1 for 20 cycles, data 0..19.
   - Required: outputs 0..19 in order, one per cycle after a 1-cycle latency, `drop_cnt`=0.
6. **Backpressure stall:**
   - Stimulus: `out_valid`=1 with `out_ready` toggling 0,0,1.
   - Required: `out_data` unchanged during the stall; the next word is presented the cycle after the handshake.
